// File: rtl/stream_demux.sv
// Packet-aware 1-to-NUM_OUT stream demultiplexer; channel locked from the first beat until in_last.
// Latency: 1 cycle, one registered buffer per output; in_ready follows space in the target buffer.
// Optional per-channel packet counters (pkt_cnt) are built when STREAM_DEMUX_PKT_CNT_EN is defined.
module stream_demux #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 2,
    parameter int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_last,
    output logic                     busy,
    output logic                     err
`ifdef STREAM_DEMUX_PKT_CNT_EN
    ,
    output logic [NUM_OUT*16-1:0]    pkt_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                   state_q, state_d;
    logic [SEL_W-1:0]         lock_ch_q, lock_ch_d;
    logic                     err_q, err_d;
    logic [NUM_OUT-1:0]       out_valid_q, out_valid_d;
    logic [NUM_OUT-1:0]       out_last_q, out_last_d;
    logic [NUM_OUT*WIDTH-1:0] out_data_q, out_data_d;

    logic [NUM_OUT-1:0] space;
    logic [NUM_OUT-1:0] load;
    logic               sel_ok;
    logic               space_sel;
    logic               space_lock;
    logic               route;
    logic               accept;
    logic [SEL_W-1:0]   tgt_ch;

    // Select decode walks every encodable value so out-of-range selects never index past the buffers.
    always_comb begin
        space      = ~out_valid_q | out_ready;
        sel_ok     = 1'b0;
        space_sel  = 1'b0;
        space_lock = 1'b0;
        for (int k = 0; k < (1 << SEL_W); k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_ok = (k < NUM_OUT);
            end
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                space_sel = space[k];
            end
            if (lock_ch_q == SEL_W'(k)) begin
                space_lock = space[k];
            end
        end
    end

    always_comb begin
        in_ready = 1'b0;
        route    = 1'b0;
        tgt_ch   = lock_ch_q;
        case (state_q)
            IDLE: begin
                tgt_ch   = in_sel;
                route    = sel_ok;
                in_ready = sel_ok ? space_sel : 1'b1;
            end
            ROUTE: begin
                route    = 1'b1;
                in_ready = space_lock;
            end
            DROP: begin
                in_ready = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        err_d     = err_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (sel_ok) begin
                        if (!in_last) begin
                            lock_ch_d = in_sel;
                            state_d   = ROUTE;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (!in_last) begin
                            state_d = DROP;
                        end
                    end
                end
                ROUTE, DROP: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // A load wins over a drain so a full buffer can stream one beat per cycle.
    always_comb begin
        load        = '0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            load[k] = accept & route & (tgt_ch == SEL_W'(k));
            if (load[k]) begin
                out_valid_d[k]              = 1'b1;
                out_last_d[k]               = in_last;
                out_data_d[k*WIDTH +: WIDTH] = in_data;
            end else if (out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            err_q       <= 1'b0;
            out_valid_q <= '0;
            out_last_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef STREAM_DEMUX_PKT_CNT_EN
    logic [NUM_OUT*16-1:0] pkt_cnt_q, pkt_cnt_d;

    // A packet counts once its last beat leaves the buffer, not when it enters.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            pkt_cnt_d[k*16 +: 16] = pkt_cnt_q[k*16 +: 16]
                                  + 16'(out_valid_q[k] & out_ready[k] & out_last_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux with NUM_OUT=3 so that select value 3 is out of range.
module tb_stream_demux;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_sel;
    logic          in_last;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]  out_last;
    logic          busy;
    logic          err;
`ifdef STREAM_DEMUX_PKT_CNT_EN
    logic [N*16-1:0] pkt_cnt;
`endif

    stream_demux #(.WIDTH(W), .NUM_OUT(N), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
`ifdef STREAM_DEMUX_PKT_CNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int last_wait   = 0;

    logic [W:0] exp_q [N][$];
    logic [W:0] mon_e;
    bit         m_busy;
    int         m_lock;
    bit         exp_err;

    // Consumer side: a beat is taken when valid & ready are seen between edges.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    vectors++;
                    if (exp_q[k].size() == 0) begin
                        miscompares++;
                        $display("FAIL mon_unexpected ch%0d got %h required none",
                                 k, {out_last[k], out_data[k*W +: W]});
                    end else begin
                        mon_e = exp_q[k].pop_front();
                        if ({out_last[k], out_data[k*W +: W]} !== mon_e) begin
                            miscompares++;
                            $display("FAIL mon_beat ch%0d got %h required %h",
                                     k, {out_last[k], out_data[k*W +: W]}, mon_e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic model_clear();
        for (int k = 0; k < N; k++) exp_q[k].delete();
        m_busy  = 1'b0;
        m_lock  = 0;
        exp_err = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = '1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Presents one beat, waits for acceptance, then checks the 1-cycle result at edge+1.
    task automatic send_beat(input logic [SW-1:0] sel, input logic [W-1:0] data, input bit last);
        int ch;
        bit ok;
        ok        = 1'b0;
        last_wait = 0;
        in_valid  = 1'b1;
        in_sel    = sel;
        in_data   = data;
        in_last   = last;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else last_wait++;
            @(posedge clk);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout sel=%0d data=%h got in_ready=0 required 1", sel, data);
            #1;
            in_valid = 1'b0;
            return;
        end
        if (!m_busy) begin
            ch = int'(sel);
            if (!last) begin
                m_busy = 1'b1;
                m_lock = ch;
            end
        end else begin
            ch = m_lock;
            if (last) m_busy = 1'b0;
        end
        if (ch >= N) exp_err = 1'b1;
        else exp_q[ch].push_back({last, data});
        #1;
        in_valid = 1'b0;
        vectors++;
        if (busy !== m_busy) begin
            miscompares++;
            $display("FAIL busy data=%h got %b required %b", data, busy, m_busy);
        end
        vectors++;
        if (err !== exp_err) begin
            miscompares++;
            $display("FAIL err data=%h got %b required %b", data, err, exp_err);
        end
        if (ch < N) begin
            vectors++;
            if (out_valid[ch] !== 1'b1 || {out_last[ch], out_data[ch*W +: W]} !== {last, data}) begin
                miscompares++;
                $display("FAIL latency ch%0d got v=%b %h required v=1 %h",
                         ch, out_valid[ch], {out_last[ch], out_data[ch*W +: W]}, {last, data});
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (out_valid !== '0 || out_last !== '0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b l=%b d=%h required zeros", out_valid, out_last, out_data);
        end
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status got busy=%b err=%b required 0 0", busy, err);
        end
    endtask

    task automatic test_single();
        out_ready = '1;
        send_beat(2'd1, 8'hA5, 1'b1);
        vectors++;
        if (out_valid !== 3'b010) begin
            miscompares++;
            $display("FAIL single_valid got %b required 010", out_valid);
        end
        idle_cycles(2);
    endtask

    task automatic test_burst();
        out_ready = '1;
        for (int i = 0; i < 4; i++) begin
            send_beat((i == 0) ? 2'd0 : 2'd1, 8'h10 + W'(i), i == 3);
            vectors++;
            if (out_valid[1] !== 1'b0 || (i > 0 && last_wait != 0)) begin
                miscompares++;
                $display("FAIL burst beat%0d got v1=%b wait=%0d required 0 0", i, out_valid[1], last_wait);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_backpressure();
        out_ready[0] = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) send_beat(2'd0, 8'h20 + W'(i), i == 2);
            end
            begin
                repeat (3) @(negedge clk);
                vectors++;
                if (in_ready !== 1'b0 || out_valid[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_stall got rdy=%b v0=%b required 0 1", in_ready, out_valid[0]);
                end
                @(posedge clk);
                #1;
                out_ready[0] = 1'b1;
            end
        join
        idle_cycles(3);
    endtask

    task automatic test_invalid();
        out_ready = '1;
        send_beat(2'd3, 8'h55, 1'b0);
        send_beat(2'd3, 8'h56, 1'b1);
        vectors++;
        if (out_valid !== '0) begin
            miscompares++;
            $display("FAIL invalid_no_out got %b required 000", out_valid);
        end
        idle_cycles(2);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky got %b required 1", err);
        end
        send_beat(2'd2, 8'h77, 1'b1);
        vectors++;
        if (out_valid !== 3'b100) begin
            miscompares++;
            $display("FAIL after_invalid got %b required 100", out_valid);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        out_ready = '1;
        send_beat(2'd1, 8'h31, 1'b0);
        send_beat(2'd1, 8'h32, 1'b0);
        out_ready = '0;
        idle_cycles(1);
        do_reset();
        vectors++;
        if (out_valid !== '0 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got v=%b busy=%b err=%b required 000 0 0", out_valid, busy, err);
        end
        send_beat(2'd0, 8'hC3, 1'b1);
        vectors++;
        if (out_valid !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_mid_first got %b required 001", out_valid);
        end
        idle_cycles(2);
    endtask

`ifdef STREAM_DEMUX_PKT_CNT_EN
    task automatic test_pkt_cnt();
        do_reset();
        vectors++;
        if (pkt_cnt !== '0) begin
            miscompares++;
            $display("FAIL cnt_reset got %h required 0", pkt_cnt);
        end
        for (int p = 0; p < 3; p++) begin
            send_beat(2'd1, 8'h40 + W'(p), 1'b0);
            send_beat(2'd1, 8'h50 + W'(p), 1'b1);
        end
        send_beat(2'd0, 8'h60, 1'b1);
        idle_cycles(3);
        vectors++;
        if (pkt_cnt[16 +: 16] !== 16'd3 || pkt_cnt[0 +: 16] !== 16'd1) begin
            miscompares++;
            $display("FAIL cnt_value got ch1=%0d ch0=%0d required 3 1", pkt_cnt[16 +: 16], pkt_cnt[0 +: 16]);
        end
        for (int i = 0; i < 65533; i++) send_beat(2'd1, W'(i), 1'b1);
        idle_cycles(3);
        vectors++;
        if (pkt_cnt[16 +: 16] !== 16'd0) begin
            miscompares++;
            $display("FAIL cnt_wrap got %0d required 0", pkt_cnt[16 +: 16]);
        end
    endtask
`endif

    task automatic test_drain();
        out_ready = '1;
        idle_cycles(4);
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (exp_q[k].size() != 0) begin
                miscompares++;
                $display("FAIL drain ch%0d got %0d pending required 0", k, exp_q[k].size());
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_last   = 1'b0;
        out_ready = '1;
        model_clear();
        idle_cycles(2);
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_invalid();
        test_reset_mid();
`ifdef STREAM_DEMUX_PKT_CNT_EN
        test_pkt_cnt();
`endif
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
